// File: rtl/frame_buffer_arbiter.sv
// Double-buffered frame store. The writer fills the back bank, and readers share the front bank
// through a fixed-priority, fully pipelined two-cycle read path. Banks swap after frame_done_in.
module frame_buffer_arbiter #(
    parameter int WIDTH          = 4,
    parameter int ADDR_BITS      = 16,
    parameter int NUM_READERS    = 2,
    parameter int SWAP_ON_VBLANK = 1
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             wr_en_in,
    input  logic [ADDR_BITS-1:0]             wr_addr_in,
    input  logic [WIDTH-1:0]                 wr_data_in,
    input  logic                             frame_done_in,
    input  logic                             vblank_in,
    input  logic                             lock_in,
    input  logic [NUM_READERS-1:0]           rd_req_in,
    input  logic [NUM_READERS*ADDR_BITS-1:0] rd_addr_in,
    output logic [WIDTH-1:0]                 rd_data_out,
    output logic [NUM_READERS-1:0]           rd_valid_out,
    output logic                             front_bank_out,
    output logic                             swap_pending_out,
    output logic                             swap_done_out,
    output logic [15:0]                      frames_out,
    output logic [15:0]                      dropped_out
);
    localparam int DEPTH = 2**ADDR_BITS;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [WIDTH-1:0] bank0_mem [DEPTH];
    logic [WIDTH-1:0] bank1_mem [DEPTH];
    logic [WIDTH-1:0] bank0_rd_q;
    logic [WIDTH-1:0] bank1_rd_q;

    logic [0:0]             state_q, state_d;
    logic                   front_q, front_d;
    logic                   swap_done_q, swap_done_d;
    logic [15:0]            frames_q, frames_d;
    logic [15:0]            dropped_q, dropped_d;
    logic                   eligible;

    logic [NUM_READERS-1:0] grant_d, grant_q;
    logic [ADDR_BITS-1:0]   gnt_addr_d;
    logic                   gnt_bank_q;
    logic [NUM_READERS-1:0] rd_valid_q;
    logic [WIDTH-1:0]       rd_data_q;

    assign eligible = !lock_in && (vblank_in || (SWAP_ON_VBLANK == 0));

    // The scan runs from the top index down, so the lowest requesting index is the one that wins.
    always_comb begin
        grant_d    = '0;
        gnt_addr_d = '0;
        for (int i = NUM_READERS - 1; i >= 0; i--) begin
            if (rd_req_in[i]) begin
                grant_d    = '0;
                grant_d[i] = 1'b1;
                gnt_addr_d = rd_addr_in[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        frames_d    = frames_q;
        dropped_d   = dropped_q;
        swap_done_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (frame_done_in) begin
                state_d = ST_PENDING;
            end
        end else begin
            if (eligible) begin
                front_d     = !front_q;
                frames_d    = frames_q + 16'd1;
                swap_done_d = 1'b1;
                state_d     = frame_done_in ? ST_PENDING : ST_IDLE;
            end else if (frame_done_in && (dropped_q != 16'hFFFF)) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    // A bank is only written while it is the back bank, so a read can never collide with a write.
    // Both banks are read at the grant edge, which also fixes the bank before any later swap.
    always_ff @(posedge clk_in) begin
        if (wr_en_in && front_q) begin
            bank0_mem[wr_addr_in] <= wr_data_in;
        end
        if (wr_en_in && !front_q) begin
            bank1_mem[wr_addr_in] <= wr_data_in;
        end
        bank0_rd_q <= bank0_mem[gnt_addr_d];
        bank1_rd_q <= bank1_mem[gnt_addr_d];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            front_q     <= 1'b0;
            swap_done_q <= 1'b0;
            frames_q    <= '0;
            dropped_q   <= '0;
            grant_q     <= '0;
            gnt_bank_q  <= 1'b0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            swap_done_q <= swap_done_d;
            frames_q    <= frames_d;
            dropped_q   <= dropped_d;
            grant_q     <= grant_d;
            gnt_bank_q  <= front_q;
            rd_valid_q  <= grant_q;
            if (|grant_q) begin
                rd_data_q <= gnt_bank_q ? bank1_rd_q : bank0_rd_q;
            end
        end
    end

    assign rd_data_out      = rd_data_q;
    assign rd_valid_out     = rd_valid_q;
    assign front_bank_out   = front_q;
    assign swap_pending_out = (state_q == ST_PENDING);
    assign swap_done_out    = swap_done_q;
    assign frames_out       = frames_q;
    assign dropped_out      = dropped_q;

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: pixel data width in bits.
REQ-002 Parameter ADDR_BITS, default 16: address width; each bank holds 2**ADDR_BITS words.
REQ-003 Parameter NUM_READERS, default 2: number of read clients; index 0 has highest priority.
REQ-004 Parameter SWAP_ON_VBLANK, default 1: 1 = swap only while vblank_in is high; 0 = swap at the first eligible cycle.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk_in  input  1  system clock.
REQ-007 rst_n_in  input  1  asynchronous active-low reset.
REQ-008 wr_en_in  input  1  write strobe into the back bank.
REQ-009 wr_addr_in  input  ADDR_BITS  write address.
REQ-010 wr_data_in  input  WIDTH  write data.
REQ-011 frame_done_in  input  1  single-cycle pulse: the writer finished a frame and requests a swap.
REQ-012 vblank_in  input  1  display vertical-blank indicator.
REQ-013 lock_in  input  1  freeze: while high, no swap occurs (export in progress).
REQ-014 rd_req_in  input  NUM_READERS  per-client read request.
REQ-015 rd_addr_in  input  NUM_READERS*ADDR_BITS  per-client address; client i uses slice [i*ADDR_BITS +: ADDR_BITS].
REQ-016 rd_data_out  output  WIDTH  shared read data.
REQ-017 rd_valid_out  output  NUM_READERS  one-hot: rd_data_out belongs to this client.
REQ-018 front_bank_out  output  1  bank currently presented to readers.
REQ-019 swap_pending_out  output  1  a swap request is waiting.
REQ-020 swap_done_out  output  1  single-cycle pulse on the cycle after a swap executes.
REQ-021 frames_out  output  16  count of executed swaps, wraps 0xFFFF->0.
REQ-022 dropped_out  output  16  count of dropped swap requests, saturates at 0xFFFF.

Function
REQ-023 The block SHALL hold two banks of 2**ADDR_BITS x WIDTH inferred block RAM; writes target bank !front_bank and readers read bank front_bank only.
REQ-024 Arbitration: each cycle, the lowest-index asserted rd_req_in bit SHALL be granted; ungranted requests are discarded, not queued.
REQ-025 Read latency: a grant in cycle N SHALL produce rd_data_out and the matching rd_valid_out bit in cycle N+2; one grant per cycle, fully pipelined.
REQ-026 The bank for a read SHALL be fixed in its grant cycle; a swap in cycle N+1 does not affect it.
REQ-027 rd_valid_out SHALL be all-zero in cycles with no grant two cycles earlier; rd_data_out then holds its last value.
REQ-028 FSM IDLE: swap_pending_out=0; on frame_done_in go to PENDING.
REQ-029 FSM PENDING: swap_pending_out=1; the swap is eligible when lock_in=0 and (vblank_in=1 or SWAP_ON_VBLANK=0); when eligible, toggle front_bank, increment frames_out, return to IDLE.
REQ-030 In PENDING, frame_done_in with the swap not eligible SHALL increment dropped_out and remain in PENDING.
REQ-031 In PENDING, frame_done_in in an eligible cycle SHALL execute the swap, remain in PENDING, and not count a drop.
REQ-032 A write in the swap cycle SHALL land in the pre-swap back bank.
REQ-033 A write with wr_en_in low SHALL have no effect; no write ever reaches the front bank.
REQ-034 lock_in rising while in PENDING SHALL hold off the swap indefinitely; the swap executes at the first eligible cycle after lock_in falls.

Reset
REQ-035 While rst_n_in is low, all registers SHALL be cleared: state IDLE, front_bank_out=0, swap_pending_out=0, swap_done_out=0, rd_valid_out=0, rd_data_out=0, frames_out=0, dropped_out=0.
REQ-036 Reset SHALL abort in-flight reads (no rd_valid_out after release) and any pending swap; RAM contents are not cleared.
REQ-037 Release from reset SHALL be taken on a clock edge; the first grant is possible in the first cycle after release.

Verification
REQ-038 Write 0x5 to addr 0x0010 and pulse frame_done_in with vblank_in=1. Then client 1 reads 0x0010 -> swap_done_out pulses, front_bank_out=1, rd_valid_out=2'b10 with rd_data_out=0x5 exactly 2 cycles after grant.
REQ-039 Both clients request in the same cycle -> only rd_valid_out=2'b01 two cycles later; client 1 receives nothing.
REQ-040 frame_done_in with vblank_in=0, then three more pulses, then vblank_in=1 -> dropped_out=3, frames_out=1, swap_pending_out falls.
REQ-041 lock_in=1 and vblank_in=1, frame_done_in pulsed -> no swap for 100 cycles; lock_in drops -> swap in that cycle, front_bank_out toggles.
REQ-042 frame_done_in in an eligible PENDING cycle -> swap executes, swap_pending_out stays 1, dropped_out unchanged.
REQ-043 Assert rst_n_in low one cycle after a grant -> rd_valid_out stays 0, all counters 0, front_bank_out=0.
